edp_slice: RTL and testbench

Parametrised EBOX data-path slice: W bits of AR, ARX, BR, BRX and MQ, the AD adder/logic unit with slice-level carry lookahead outputs, a local fast-memory (FM) bank with stored parity and sticky parity-error checking, and a registered EBUS/diagnostic read port. Slices are stacked side by side to form the full 36-bit data path, and the lookahead logic joins their carries. Vectors are [W-1:0] with index 0 the slice LSB, which is the carry-in end. This generation adds a configurable width and FM depth, a registered FM read with write bypass, and local parity checking with error injection.

---
 rtl/edp_slice.sv | 214 +++++++++++++++++++++
 tb/tb_edp_slice.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edp_slice.sv
// EBOX data-path slice: AR/ARX/BR/BRX/MQ, AD adder/logic unit with slice carry
// lookahead, parity-protected fast-memory bank and a registered EBUS/diag port.
module edp_slice #(
    parameter int W           = 6,
    parameter int FM_ADR_BITS = 7
) (
    input  logic                   clk_edp_h,
    input  logic                   edp_reset_l,
    input  logic [3:0]             cram_ad_sel_h,
    input  logic [1:0]             cram_ada_sel_h,
    input  logic [1:0]             cram_adb_sel_h,
    input  logic [W-1:0]           cram_nr_h,
    input  logic                   ad_cry_in_h,
    input  logic                   ctl_arr_load_h,
    input  logic                   ctl_arr_clr_h,
    input  logic [1:0]             ctl_arr_sel_h,
    input  logic                   ctl_arx_load_h,
    input  logic [1:0]             ctl_arxr_sel_h,
    input  logic                   cram_br_load_h,
    input  logic                   cram_brx_load_h,
    input  logic [1:0]             ctl_mq_sel_h,
    input  logic                   mq_left_in_h,
    input  logic                   mq_right_in_h,
    input  logic [W-1:0]           cache_data_h,
    input  logic [W-1:0]           sh_h,
    input  logic [W-1:0]           armm_h,
    input  logic [FM_ADR_BITS-1:0] apr_fm_adr_h,
    input  logic                   con_fm_write_l,
    input  logic                   diag_fm_par_inv_h,
    input  logic                   ctl_fm_par_clr_h,
    input  logic                   ctl_ad_to_ebus_h,
    input  logic                   diag_read_func_h,
    input  logic [2:0]             diag_sel_h,
    output logic [W-1:0]           ar_h,
    output logic [W-1:0]           arx_h,
    output logic [W-1:0]           br_h,
    output logic [W-1:0]           brx_h,
    output logic [W-1:0]           mq_h,
    output logic [W-1:0]           ad_h,
    output logic                   ad_cry_out_h,
    output logic                   ad_cg_h,
    output logic                   ad_cp_h,
    output logic                   ad_eq0_l,
    output logic [W-1:0]           fm_q_h,
    output logic                   edp_fm_parity_h,
    output logic                   edp_fm_par_err_h,
    output logic [W-1:0]           ebus_d_h
);
    localparam int FM_WORDS = 1 << FM_ADR_BITS;

    logic [W-1:0] ar_q, ar_d, arx_q, arx_d, br_q, br_d, brx_q, brx_d, mq_q, mq_d;
    logic [W-1:0] fm_q_q, fm_q_d, ebus_q, ebus_d;
    logic         fm_par_q, fm_par_d, fm_vld_q, fm_vld_d, par_err_q, par_err_d;
    logic [W-1:0] fm_mem [FM_WORDS];
    logic         fm_par_mem [FM_WORDS];
    logic [FM_WORDS-1:0] fm_written_q;

    logic [W-1:0] a_op, b_op, b_arith, ad;
    logic [W:0]   raw, sum;
    logic         arith, fm_wr, wr_par;

    always_comb begin
        a_op    = '0;
        b_op    = '0;
        b_arith = '0;
        arith   = 1'b0;
        ad      = '0;
        unique case (cram_ada_sel_h)
            2'd0:    a_op = ar_q;
            2'd1:    a_op = arx_q;
            2'd2:    a_op = mq_q;
            default: a_op = '0;
        endcase
        unique case (cram_adb_sel_h)
            2'd0:    b_op = br_q;
            2'd1:    b_op = brx_q;
            2'd2:    b_op = fm_q_q;
            default: b_op = cram_nr_h;
        endcase
        case (cram_ad_sel_h)
            4'd0: begin b_arith = b_op;  arith = 1'b1; end
            4'd1: begin b_arith = ~b_op; arith = 1'b1; end
            4'd8: begin b_arith = '0;    arith = 1'b1; end
            4'd9: begin b_arith = '1;    arith = 1'b1; end
            default: arith = 1'b0;
        endcase
        // raw excludes carry-in so it yields the slice generate/propagate terms
        raw = {1'b0, a_op} + {1'b0, b_arith};
        sum = raw + {{W{1'b0}}, ad_cry_in_h};
        case (cram_ad_sel_h)
            4'd2:    ad = a_op & b_op;
            4'd3:    ad = a_op | b_op;
            4'd4:    ad = a_op ^ b_op;
            4'd6:    ad = b_op;
            4'd7:    ad = ~a_op;
            default: ad = arith ? sum[W-1:0] : a_op;
        endcase
    end

    assign ad_h         = ad;
    assign ad_cry_out_h = arith & sum[W];
    assign ad_cg_h      = arith & raw[W];
    assign ad_cp_h      = arith & (raw == {1'b0, {W{1'b1}}});
    assign ad_eq0_l     = |ad;

    always_comb begin
        ar_d  = ar_q;
        arx_d = arx_q;
        br_d  = cram_br_load_h  ? ar_q  : br_q;
        brx_d = cram_brx_load_h ? arx_q : brx_q;
        mq_d  = mq_q;
        if (ctl_arr_clr_h) begin
            ar_d = '0;
        end else if (ctl_arr_load_h) begin
            unique case (ctl_arr_sel_h)
                2'd0:    ar_d = ad;
                2'd1:    ar_d = cache_data_h;
                2'd2:    ar_d = sh_h;
                default: ar_d = armm_h;
            endcase
        end
        if (ctl_arx_load_h) begin
            unique case (ctl_arxr_sel_h)
                2'd0:    arx_d = ad;
                2'd1:    arx_d = cache_data_h;
                2'd2:    arx_d = sh_h;
                default: arx_d = ar_q;
            endcase
        end
        unique case (ctl_mq_sel_h)
            2'd0:    mq_d = mq_q;
            2'd1:    mq_d = ad;
            2'd2:    mq_d = {mq_q[W-2:0], mq_left_in_h};
            default: mq_d = {mq_right_in_h, mq_q[W-1:1]};
        endcase
    end

    // A write always targets the read address, so a write bypasses the array.
    always_comb begin
        fm_wr     = ~con_fm_write_l;
        wr_par    = (^ar_q) ^ diag_fm_par_inv_h;
        fm_q_d    = fm_wr ? ar_q   : fm_mem[apr_fm_adr_h];
        fm_par_d  = fm_wr ? wr_par : fm_par_mem[apr_fm_adr_h];
        fm_vld_d  = fm_wr | fm_written_q[apr_fm_adr_h];
        par_err_d = ctl_fm_par_clr_h ? 1'b0
                  : (par_err_q | (fm_vld_q & ((^fm_q_q) != fm_par_q)));
        ebus_d    = '0;
        if (ctl_ad_to_ebus_h) begin
            ebus_d = ad;
        end else if (diag_read_func_h) begin
            unique case (diag_sel_h)
                3'd0: ebus_d = ar_q;
                3'd1: ebus_d = arx_q;
                3'd2: ebus_d = br_q;
                3'd3: ebus_d = brx_q;
                3'd4: ebus_d = mq_q;
                3'd5: ebus_d = fm_q_q;
                3'd6: begin
                    ebus_d    = '0;
                    ebus_d[1] = fm_par_q;
                    ebus_d[0] = par_err_q;
                end
                default: ebus_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_edp_h) begin
        if (fm_wr) begin
            fm_mem[apr_fm_adr_h]     <= ar_q;
            fm_par_mem[apr_fm_adr_h] <= wr_par;
        end
    end

    always_ff @(posedge clk_edp_h or negedge edp_reset_l) begin
        if (!edp_reset_l) begin
            ar_q         <= '0;
            arx_q        <= '0;
            br_q         <= '0;
            brx_q        <= '0;
            mq_q         <= '0;
            fm_q_q       <= '0;
            fm_par_q     <= 1'b0;
            fm_vld_q     <= 1'b0;
            par_err_q    <= 1'b0;
            ebus_q       <= '0;
            fm_written_q <= '0;
        end else begin
            ar_q      <= ar_d;
            arx_q     <= arx_d;
            br_q      <= br_d;
            brx_q     <= brx_d;
            mq_q      <= mq_d;
            fm_q_q    <= fm_q_d;
            fm_par_q  <= fm_par_d;
            fm_vld_q  <= fm_vld_d;
            par_err_q <= par_err_d;
            ebus_q    <= ebus_d;
            if (fm_wr) begin
                fm_written_q[apr_fm_adr_h] <= 1'b1;
            end
        end
    end

    assign ar_h             = ar_q;
    assign arx_h            = arx_q;
    assign br_h             = br_q;
    assign brx_h            = brx_q;
    assign mq_h             = mq_q;
    assign fm_q_h           = fm_q_q;
    assign edp_fm_parity_h  = fm_par_q;
    assign edp_fm_par_err_h = par_err_q;
    assign ebus_d_h         = ebus_q;
endmodule

// File: tb/tb_edp_slice.sv
// Directed bench for edp_slice: a behavioural model checked every cycle plus
// hand-computed literal expectations from the slice's worked examples.
module tb_edp_slice;
    localparam int W  = 6;
    localparam int AB = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [3:0]    ad_sel;
    logic [1:0]    ada_sel, adb_sel, arr_sel, arxr_sel, mq_sel;
    logic [W-1:0]  nr, cache_d, sh_d, armm_d;
    logic          cin, arr_load, arr_clr, arx_load, br_load, brx_load;
    logic          left_in, right_in, fm_write_l, par_inv, par_clr, ad_to_ebus, diag_read;
    logic [AB-1:0] fm_adr;
    logic [2:0]    diag_sel;
    logic [W-1:0]  ar, arx, br, brx, mq, ad, fmq, ebus;
    logic          cry, cg, cp, eq0_l, fpar, ferr;

    edp_slice #(.W(W), .FM_ADR_BITS(AB)) dut (
        .clk_edp_h(clk), .edp_reset_l(rst_n), .cram_ad_sel_h(ad_sel),
        .cram_ada_sel_h(ada_sel), .cram_adb_sel_h(adb_sel), .cram_nr_h(nr),
        .ad_cry_in_h(cin), .ctl_arr_load_h(arr_load), .ctl_arr_clr_h(arr_clr),
        .ctl_arr_sel_h(arr_sel), .ctl_arx_load_h(arx_load), .ctl_arxr_sel_h(arxr_sel),
        .cram_br_load_h(br_load), .cram_brx_load_h(brx_load), .ctl_mq_sel_h(mq_sel),
        .mq_left_in_h(left_in), .mq_right_in_h(right_in), .cache_data_h(cache_d),
        .sh_h(sh_d), .armm_h(armm_d), .apr_fm_adr_h(fm_adr), .con_fm_write_l(fm_write_l),
        .diag_fm_par_inv_h(par_inv), .ctl_fm_par_clr_h(par_clr),
        .ctl_ad_to_ebus_h(ad_to_ebus), .diag_read_func_h(diag_read), .diag_sel_h(diag_sel),
        .ar_h(ar), .arx_h(arx), .br_h(br), .brx_h(brx), .mq_h(mq), .ad_h(ad),
        .ad_cry_out_h(cry), .ad_cg_h(cg), .ad_cp_h(cp), .ad_eq0_l(eq0_l),
        .fm_q_h(fmq), .edp_fm_parity_h(fpar), .edp_fm_par_err_h(ferr), .ebus_d_h(ebus)
    );

    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %o expected %o", name, act, exp);
    endtask

    // Behavioural model state
    logic [W-1:0] mAr, mArx, mBr, mBrx, mMq, mFmq, mEbus;
    logic         mPar = 1'b0, mErr = 1'b0, mVld = 1'b0;
    bit           mFmKnown = 1'b0;
    logic [W-1:0] mMem [int];
    logic         mMemPar [int];
    bit           mWr [int];

    function automatic logic [W-1:0] selA(input logic [1:0] s);
        case (s)
            2'd0:    return mAr;
            2'd1:    return mArx;
            2'd2:    return mMq;
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] selB(input logic [1:0] s);
        case (s)
            2'd0:    return mBr;
            2'd1:    return mBrx;
            2'd2:    return mFmq;
            default: return nr;
        endcase
    endfunction

    function automatic void adModel(input int f, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic ci, output logic [W-1:0] r,
                                    output logic co, output logic g, output logic p);
        longint mask = (longint'(1) << W) - 1;
        longint sa = longint'(a);
        longint sb;
        longint s;
        bit arithOp = 1'b1;
        case (f)
            0:       sb = longint'(b);
            1:       sb = mask - longint'(b);
            8:       sb = 0;
            9:       sb = mask;
            default: begin sb = 0; arithOp = 1'b0; end
        endcase
        co = 1'b0; g = 1'b0; p = 1'b0;
        if (arithOp) begin
            s  = sa + sb + longint'(ci);
            r  = W'(s & mask);
            co = (s > mask);
            g  = (sa + sb > mask);
            p  = (sa + sb == mask);
        end else begin
            case (f)
                2:       r = a & b;
                3:       r = a | b;
                4:       r = a ^ b;
                6:       r = b;
                7:       r = ~a;
                default: r = a;
            endcase
        end
    endfunction

    logic [W-1:0] nAd, nAr, nArx, nMq, nEbus;
    logic         nCry, nCg, nCp, nErr;
    int           adr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mAr = '0; mArx = '0; mBr = '0; mBrx = '0; mMq = '0; mFmq = '0; mEbus = '0;
            mPar = 1'b0; mErr = 1'b0; mVld = 1'b0; mFmKnown = 1'b1;
            mWr.delete();
        end else begin
            adModel(int'(ad_sel), selA(ada_sel), selB(adb_sel), cin, nAd, nCry, nCg, nCp);
            nAr = mAr;
            if (arr_clr) nAr = '0;
            else if (arr_load) nAr = (arr_sel == 0) ? nAd : (arr_sel == 1) ? cache_d
                                   : (arr_sel == 2) ? sh_d : armm_d;
            nArx = mArx;
            if (arx_load) nArx = (arxr_sel == 0) ? nAd : (arxr_sel == 1) ? cache_d
                               : (arxr_sel == 2) ? sh_d : mAr;
            case (mq_sel)
                2'd0:    nMq = mMq;
                2'd1:    nMq = nAd;
                2'd2:    nMq = W'((int'(mMq) * 2 + int'(left_in)) % (1 << W));
                default: nMq = W'(int'(mMq) / 2 + int'(right_in) * (1 << (W - 1)));
            endcase
            nEbus = '0;
            if (ad_to_ebus) nEbus = nAd;
            else if (diag_read) begin
                case (diag_sel)
                    3'd0: nEbus = mAr;
                    3'd1: nEbus = mArx;
                    3'd2: nEbus = mBr;
                    3'd3: nEbus = mBrx;
                    3'd4: nEbus = mMq;
                    3'd5: nEbus = mFmq;
                    3'd6: nEbus = W'(int'(mPar) * 2 + int'(mErr));
                    default: nEbus = '0;
                endcase
            end
            nErr = par_clr ? 1'b0 : (mErr | (mVld && ((^mFmq) != mPar)));
            if (cram_br_load_h_model()) mBr = mAr;
            if (brx_load) mBrx = mArx;
            adr = int'(fm_adr);
            if (!fm_write_l) begin
                mMem[adr] = mAr; mMemPar[adr] = (^mAr) ^ par_inv; mWr[adr] = 1'b1;
            end
            if (mMem.exists(adr)) begin
                mFmq = mMem[adr]; mPar = mMemPar[adr]; mFmKnown = 1'b1;
            end else begin
                mFmKnown = 1'b0;
            end
            mVld = mWr.exists(adr);
            mAr = nAr; mArx = nArx; mMq = nMq; mEbus = nEbus; mErr = nErr;
        end
    end

    function automatic bit cram_br_load_h_model();
        return br_load;
    endfunction

    logic [W-1:0] cAd;
    logic         cCry, cCg, cCp;
    always @(negedge clk) begin
        checkOutput("ar", ar, mAr);
        checkOutput("arx", arx, mArx);
        checkOutput("br", br, mBr);
        checkOutput("brx", brx, mBrx);
        checkOutput("mq", mq, mMq);
        checkOutput("ebus", ebus, mEbus);
        checkOutput("par_err", W'(ferr), W'(mErr));
        if (mFmKnown) begin
            checkOutput("fm_q", fmq, mFmq);
            checkOutput("fm_par", W'(fpar), W'(mPar));
        end
        if (!(adb_sel == 2'd2 && !mFmKnown)) begin
            adModel(int'(ad_sel), selA(ada_sel), selB(adb_sel), cin, cAd, cCry, cCg, cCp);
            checkOutput("ad", ad, cAd);
            checkOutput("cry_out", W'(cry), W'(cCry));
            checkOutput("cg", W'(cg), W'(cCg));
            checkOutput("cp", W'(cp), W'(cCp));
            checkOutput("eq0_l", W'(eq0_l), W'(cAd != 0));
        end
    end

    // Advance one clock, then return single-cycle controls to idle.
    task automatic applyStimulus();
        @(posedge clk);
        #2;
        arr_load = 0; arr_clr = 0; arx_load = 0; br_load = 0; brx_load = 0;
        mq_sel = 0; fm_write_l = 1; par_inv = 0; par_clr = 0;
    endtask

    task automatic loadAr(input logic [W-1:0] v);
        applyStimulus();
        arr_load = 1; arr_sel = 1; cache_d = v;
    endtask

    initial begin
        rst_n = 0; ad_sel = 0; ada_sel = 0; adb_sel = 0; nr = 0; cin = 0;
        arr_load = 0; arr_clr = 0; arr_sel = 0; arx_load = 0; arxr_sel = 0;
        br_load = 0; brx_load = 0; mq_sel = 0; left_in = 0; right_in = 0;
        cache_d = 0; sh_d = 0; armm_d = 0; fm_adr = 0; fm_write_l = 1;
        par_inv = 0; par_clr = 0; ad_to_ebus = 0; diag_read = 0; diag_sel = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        checkOutput("reset ar", ar, 6'o00);
        checkOutput("reset fm_q", fmq, 6'o00);
        checkOutput("reset ebus", ebus, 6'o00);

        // Add: 52 + 25
        loadAr(6'o25); applyStimulus(); br_load = 1;
        loadAr(6'o52); applyStimulus();
        ad_sel = 0; ada_sel = 0; adb_sel = 0; cin = 0; #1;
        checkOutput("add ad", ad, 6'o77);
        checkOutput("add cry", W'(cry), 6'o00);
        checkOutput("add cp", W'(cp), 6'o01);
        checkOutput("add cg", W'(cg), 6'o00);
        cin = 1; #1;
        checkOutput("add+1 ad", ad, 6'o00);
        checkOutput("add+1 cry", W'(cry), 6'o01);
        checkOutput("add+1 eq0_l", W'(eq0_l), 6'o00);

        // Subtract 5 - 3 then AR<=AD with BR<=old AR
        loadAr(6'd3); applyStimulus(); br_load = 1;
        loadAr(6'd5); applyStimulus();
        ad_sel = 1; cin = 1; #1;
        checkOutput("sub ad", ad, 6'd2);
        checkOutput("sub cry", W'(cry), 6'o01);
        arr_load = 1; arr_sel = 0; br_load = 1;
        applyStimulus();
        checkOutput("sub ar", ar, 6'd2);
        checkOutput("sub br", br, 6'd5);

        // FM write, read-back and same-cycle bypass
        loadAr(6'o41); applyStimulus(); fm_adr = 7; fm_write_l = 0;
        applyStimulus(); applyStimulus();
        checkOutput("fm read", fmq, 6'o41);
        checkOutput("fm parity", W'(fpar), 6'o00);
        checkOutput("fm no err", W'(ferr), 6'o00);
        loadAr(6'o33); applyStimulus(); fm_write_l = 0;
        applyStimulus();
        checkOutput("fm bypass", fmq, 6'o33);

        // Injected parity error, sticky, then cleared off the bad word
        loadAr(6'o07); applyStimulus(); fm_adr = 9; fm_write_l = 0; par_inv = 1;
        applyStimulus(); applyStimulus();
        checkOutput("par err set", W'(ferr), 6'o01);
        applyStimulus();
        checkOutput("par err held", W'(ferr), 6'o01);
        fm_adr = 7; par_clr = 1;
        applyStimulus();
        checkOutput("par err clr", W'(ferr), 6'o00);
        applyStimulus();
        checkOutput("par err stays clr", W'(ferr), 6'o00);

        // Directed sweep of functions, sources and diag selects, model-checked
        for (int i = 0; i < 16; i++) begin
            applyStimulus();
            ad_sel = 4'(i); ada_sel = 2'(i % 4); adb_sel = 2'((i + 1) % 4); cin = i[0];
            nr = W'(i * 5 + 3); cache_d = W'(i * 11); sh_d = W'(i * 13); armm_d = W'(i * 7);
            arr_load = (i % 3 == 0); arr_clr = (i == 6); arr_sel = 2'(i % 4);
            arx_load = i[0]; arxr_sel = 2'((i + 1) % 4);
            br_load = (i % 5 == 0); brx_load = (i % 3 == 1); mq_sel = 2'(i % 4);
            left_in = i[1]; right_in = i[2]; fm_write_l = (i != 12);
            diag_read = 1; diag_sel = 3'(i % 8); ad_to_ebus = (i == 9);
        end
        applyStimulus();
        diag_read = 0; ad_to_ebus = 0; cin = 0;

        // MQ shifts
        loadAr(6'o01); applyStimulus(); ad_sel = 5; ada_sel = 0; mq_sel = 1;
        applyStimulus(); mq_sel = 2; left_in = 1;
        applyStimulus();
        checkOutput("mq left", mq, 6'o03);
        mq_sel = 3; right_in = 1;
        applyStimulus();
        checkOutput("mq right", mq, 6'o41);

        // EBUS diag read of MQ, then AD priority
        loadAr(6'o17); applyStimulus(); ad_sel = 5; ada_sel = 0; mq_sel = 1;
        applyStimulus(); diag_read = 1; diag_sel = 4;
        applyStimulus();
        checkOutput("ebus mq", ebus, 6'o17);
        ad_to_ebus = 1; ada_sel = 3; ad_sel = 7; #1;
        checkOutput("ad not zero", ad, 6'o77);
        applyStimulus();
        checkOutput("ebus ad wins", ebus, 6'o77);

        // Asynchronous reset mid-run, then first edge after release is normal
        applyStimulus();
        ad_sel = 6; adb_sel = 3; nr = 6'o12; rst_n = 0; #1;
        checkOutput("rst ar", ar, 6'o00);
        checkOutput("rst mq", mq, 6'o00);
        checkOutput("rst ebus", ebus, 6'o00);
        checkOutput("rst fm_q", fmq, 6'o00);
        checkOutput("rst err", W'(ferr), 6'o00);
        checkOutput("rst ad nr", ad, 6'o12);
        applyStimulus();
        rst_n = 1; arr_load = 1; arr_sel = 1; cache_d = 6'o12; ad_to_ebus = 0; diag_read = 0;
        applyStimulus();
        checkOutput("post-rst ar", ar, 6'o12);
        applyStimulus();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
